// File: rtl/ahb_lite_master.sv
// ahb_lite_master: valid/ready command stream to single NONSEQ AHB-lite word transfers.
// Optional ERROR response handling is enabled by defining AHB_MASTER_HRESP_EN.
module ahb_lite_master #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [ADDR_W-1:0] haddr,
  output logic [DATA_W-1:0] hwdata,
  input  logic [DATA_W-1:0] hrdata,
  input  logic              hready
`ifdef AHB_MASTER_HRESP_EN
  ,
  input  logic              hresp
`endif
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;

  // Low two bits are the {address phase, data phase} valid flags.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'b000,
    ST_DATA      = 3'b001,
    ST_ADDR      = 3'b010,
    ST_ADDR_DATA = 3'b011,
    ST_ERR1      = 3'b100
  } state_e;

  state_e            state_q;
  logic [1:0]        htrans_q;
  logic [ADDR_W-1:0] haddr_q;
  logic              hwrite_q;
  logic [DATA_W-1:0] hwdata_q;
  logic [DATA_W-1:0] wbuf_q;
  logic              dwrite_q;
  logic              rsp_valid_q;
  logic              rsp_write_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              aph;
  logic              dph;
  logic              accept;

  assign aph = state_q[1];
  assign dph = state_q[0];

`ifdef AHB_MASTER_HRESP_EN
  logic rsp_err_q;
  logic replay_q;
  assign cmd_ready = hready & ~hreset & (state_q != ST_ERR1);
  assign rsp_err   = rsp_err_q;
`else
  assign cmd_ready = hready & ~hreset;
  assign rsp_err   = 1'b0;
`endif

  assign accept    = cmd_valid & cmd_ready;
  assign htrans    = htrans_q;
  assign haddr     = haddr_q;
  assign hwrite    = hwrite_q;
  assign hwdata    = hwdata_q;
  assign hsize     = 3'b010;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;

  // Bus FSM: address/data phase pipeline with registered bus and response outputs
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q     <= ST_IDLE;
      htrans_q    <= TR_IDLE;
      haddr_q     <= '0;
      hwrite_q    <= 1'b0;
      hwdata_q    <= '0;
      wbuf_q      <= '0;
      dwrite_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef AHB_MASTER_HRESP_EN
      rsp_err_q   <= 1'b0;
      replay_q    <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
`ifdef AHB_MASTER_HRESP_EN
      if (state_q == ST_ERR1) begin
        if (hready) begin
          rsp_valid_q <= 1'b1;
          rsp_write_q <= dwrite_q;
          rsp_rdata_q <= '0;
          rsp_err_q   <= 1'b1;
          replay_q    <= 1'b0;
          if (replay_q) begin
            htrans_q <= TR_NONSEQ;
            state_q  <= ST_ADDR;
          end else begin
            state_q  <= ST_IDLE;
          end
        end
      end else if (dph && !hready && hresp) begin
        // Cancel any pending address phase; it stays in haddr/hwrite/wbuf for replay.
        htrans_q <= TR_IDLE;
        replay_q <= aph;
        state_q  <= ST_ERR1;
      end else
`endif
      if (hready) begin
`ifdef AHB_MASTER_HRESP_EN
        rsp_err_q <= 1'b0;
`endif
        if (dph) begin
          rsp_valid_q <= 1'b1;
          rsp_write_q <= dwrite_q;
          rsp_rdata_q <= dwrite_q ? '0 : hrdata;
        end
        if (aph) begin
          dwrite_q <= hwrite_q;
          if (hwrite_q) begin
            hwdata_q <= wbuf_q;
          end
        end
        if (accept) begin
          htrans_q <= TR_NONSEQ;
          haddr_q  <= cmd_addr;
          hwrite_q <= cmd_write;
          wbuf_q   <= cmd_wdata;
        end else begin
          htrans_q <= TR_IDLE;
        end
        state_q <= state_e'({1'b0, accept, aph});
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_master.sv
// tb_ahb_lite_master: directed and random checks of ahb_lite_master
// against a command-level memory model and a behavioural AHB-lite slave.
`timescale 1ns/1ps
module tb_ahb_lite_master;

  logic        hclk = 1'b0;
  logic        hreset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_write = 1'b0;
  logic [7:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        cmd_ready;
  logic        rsp_valid;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [7:0]  haddr;
  logic [31:0] hwdata;
  logic [31:0] hrdata = '0;
  logic        hready = 1'b1;

  int total = 0;
  int bad = 0;

  ahb_lite_master #(.ADDR_W(8), .DATA_W(32)) dut (
    .hclk(hclk), .hreset(hreset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
    .haddr(haddr), .hwdata(hwdata),
    .hrdata(hrdata), .hready(hready)
  );

  always #5 hclk = ~hclk;

  function automatic logic [31:0] init_val(input int i);
    return 32'hA500_0000 ^ (i * 32'h0001_0203);
  endfunction

  // Behavioural slave: byte-addressed word memory, configurable wait states.
  logic [31:0] smem [256];
  logic        s_act = 1'b0;
  logic        s_write = 1'b0;
  logic [7:0]  s_addr = '0;
  int          s_wait = 0;
  int          wait_mode = 0;

  always @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      s_act = 1'b0;
      s_wait = 0;
    end else if (hready) begin
      if (s_act && s_write) smem[s_addr] = hwdata;
      s_act = (htrans == 2'b10);
      s_addr = haddr;
      s_write = hwrite;
      s_wait = (wait_mode < 0) ? int'($urandom_range(0, 2)) : wait_mode;
    end else if (s_wait > 0) begin
      s_wait = s_wait - 1;
    end
  end

  always @(negedge hclk) begin
    hready = !(s_act && s_wait > 0);
    hrdata = (s_act && !s_write && s_wait == 0) ? smem[s_addr] : 32'hDEAD_BEEF;
  end

  // Reference model: commands execute in order against a flat memory.
  typedef struct packed {
    logic        w;
    logic [31:0] d;
  } rsp_t;

  logic [31:0] ref_mem [256];
  rsp_t exp_q[$];
  rsp_t obs_q[$];
  int   acc_cyc[$];
  int   rsp_cyc[$];
  int   cyc = 0;
  int   acc_cnt = 0;

  always @(posedge hclk) begin
    cyc = cyc + 1;
    if (!hreset && cmd_valid && cmd_ready) begin
      acc_cnt = acc_cnt + 1;
      acc_cyc.push_back(cyc);
      if (cmd_write) begin
        ref_mem[cmd_addr] = cmd_wdata;
        exp_q.push_back(rsp_t'{1'b1, 32'h0});
      end else begin
        exp_q.push_back(rsp_t'{1'b0, ref_mem[cmd_addr]});
      end
    end
  end

  always @(negedge hclk) begin
    if (rsp_valid) begin
      obs_q.push_back(rsp_t'{rsp_write, rsp_rdata});
      rsp_cyc.push_back(cyc);
    end
  end

  // Bus outputs must not move across a cycle in which hready was low.
  int          stab_err = 0;
  logic        plow = 1'b0;
  logic [42:0] pbus = '0;

  always @(posedge hclk) begin
    if (!hreset && plow && pbus !== {htrans, haddr, hwrite, hwdata}) stab_err++;
    plow = !hreset && !hready;
    pbus = {htrans, haddr, hwrite, hwdata};
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic w, input logic [7:0] a,
                       input logic [31:0] d, input bit hold);
    int n = acc_cnt;
    int t = 0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    do begin
      @(negedge hclk);
      t++;
    end while (acc_cnt == n && t < 50);
    if (acc_cnt == n) begin
      total++;
      bad++;
      $error("FAIL accept_timeout observed=%0d expected=%0d", acc_cnt, n + 1);
    end
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic drain_check(input string tag, input int n, input int lat);
    chk({tag, "_nrsp"}, obs_q.size(), n);
    chk({tag, "_nexp"}, exp_q.size(), n);
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      chk($sformatf("%s_rsp%0d", tag, i), obs_q[i], exp_q[i]);
      if (lat >= 0) chk($sformatf("%s_lat%0d", tag, i), rsp_cyc[i] - acc_cyc[i], lat);
    end
    obs_q.delete();
    exp_q.delete();
    acc_cyc.delete();
    rsp_cyc.delete();
  endtask

  initial begin
    logic        w;
    logic [7:0]  a;
    logic [31:0] d;

    for (int i = 0; i < 256; i++) begin
      smem[i] = init_val(i);
      ref_mem[i] = init_val(i);
    end

    // Reset held 5 cycles
    hreset = 1'b1;
    repeat (5) @(negedge hclk);
    chk("rst_htrans", htrans, 2'b00);
    chk("rst_hwrite", hwrite, 1'b0);
    chk("rst_haddr", haddr, 8'h00);
    chk("rst_hwdata", hwdata, 32'h0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    hreset = 1'b0;
    @(negedge hclk);

    // Single write, zero waits
    wait_mode = 0;
    issue(1'b1, 8'h0D, 32'h5A5A_5A5A, 1'b0);
    chk("w1_htrans", htrans, 2'b10);
    chk("w1_haddr", haddr, 8'h0D);
    chk("w1_hwrite", hwrite, 1'b1);
    chk("w1_hsize", hsize, 3'b010);
    @(negedge hclk);
    chk("w1_idle", htrans, 2'b00);
    chk("w1_hwdata", hwdata, 32'h5A5A_5A5A);
    chk("w1_no_rsp_yet", rsp_valid, 1'b0);
    @(negedge hclk);
    chk("w1_rsp_valid", rsp_valid, 1'b1);
    chk("w1_rsp_write", rsp_write, 1'b1);
    chk("w1_mem", smem[8'h0D], 32'h5A5A_5A5A);
    @(negedge hclk);
    chk("w1_rsp_pulse", rsp_valid, 1'b0);
    drain_check("w1", 1, 2);

    // Read with two slave wait states
    smem[8'h0C] = 32'h1234_5678;
    ref_mem[8'h0C] = 32'h1234_5678;
    wait_mode = 2;
    issue(1'b0, 8'h0C, 32'h0, 1'b0);
    chk("r_htrans", htrans, 2'b10);
    chk("r_haddr", haddr, 8'h0C);
    chk("r_hwrite", hwrite, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge hclk);
      chk($sformatf("r_wait%0d_htrans", k), htrans, 2'b00);
      chk($sformatf("r_wait%0d_haddr", k), haddr, 8'h0C);
      chk($sformatf("r_wait%0d_rsp", k), rsp_valid, 1'b0);
    end
    @(negedge hclk);
    chk("r_rsp_valid", rsp_valid, 1'b1);
    chk("r_rsp_write", rsp_write, 1'b0);
    chk("r_rsp_rdata", rsp_rdata, 32'h1234_5678);
    @(negedge hclk);
    drain_check("r", 1, 4);

    // Three back-to-back writes with cmd_valid held
    wait_mode = 0;
    issue(1'b1, 8'h00, 32'h11, 1'b1);
    chk("b0_htrans", htrans, 2'b10);
    chk("b0_haddr", haddr, 8'h00);
    issue(1'b1, 8'h04, 32'h22, 1'b1);
    chk("b1_htrans", htrans, 2'b10);
    chk("b1_haddr", haddr, 8'h04);
    issue(1'b1, 8'h08, 32'h33, 1'b0);
    chk("b2_htrans", htrans, 2'b10);
    chk("b2_haddr", haddr, 8'h08);
    repeat (4) @(negedge hclk);
    chk("b_mem0", smem[8'h00], 32'h11);
    chk("b_mem8", smem[8'h08], 32'h33);
    if (rsp_cyc.size() == 3) chk("b_rsp_consec", rsp_cyc[2] - rsp_cyc[0], 2);
    else chk("b_rsp_count", rsp_cyc.size(), 3);
    drain_check("b", 3, 2);

    // Reset during the data phase of a write
    issue(1'b1, 8'h10, 32'hCAFE_F00D, 1'b0);
    @(negedge hclk);
    chk("x_dph_hwdata", hwdata, 32'hCAFE_F00D);
    hreset = 1'b1;
    #1;
    chk("x_htrans", htrans, 2'b00);
    chk("x_haddr", haddr, 8'h00);
    chk("x_hwrite", hwrite, 1'b0);
    chk("x_hwdata", hwdata, 32'h0);
    chk("x_cmd_ready", cmd_ready, 1'b0);
    chk("x_rsp_valid", rsp_valid, 1'b0);
    repeat (2) @(negedge hclk);
    hreset = 1'b0;
    repeat (3) @(negedge hclk);
    chk("x_no_rsp", obs_q.size(), 0);
    chk("x_mem_untouched", smem[8'h10], init_val(8'h10));
    ref_mem[8'h10] = init_val(8'h10);
    obs_q.delete();
    exp_q.delete();
    acc_cyc.delete();
    rsp_cyc.delete();

    // Random traffic with random wait states
    wait_mode = -1;
    for (int k = 0; k < 80; k++) begin
      w = 1'($urandom_range(0, 1));
      a = 8'($urandom_range(0, 31));
      d = $urandom;
      issue(w, a, d, 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge hclk);
    end
    repeat (12) @(negedge hclk);
    drain_check("rnd", 80, -1);
    chk("wait_stable", stab_err, 0);
    chk("rnd_rsp_err", rsp_err, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
